regfile_wb_queue: RTL and testbench

//   Writer side of the register-file write port: buffers completed results and drives

---
 rtl/regfile_wb_queue.sv | 140 ++++++++++++++
 tb/tb_regfile_wb_queue.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// Register-file writeback queue: buffers results (including jal link writes) and retires
// one write per cycle, with youngest-match forwarding on two lookup ports.
module regfile_wb_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [4:0]                 in_waddr,
   input  logic [DW-1:0]              in_wdata,
   input  logic                       in_link,
   input  logic [DW-1:0]              in_pc,
   input  logic                       flush,
   output logic                       rf_we,
   output logic [4:0]                 rf_wreg,
   output logic [DW-1:0]              rf_wdata,
   input  logic [4:0]                 qa_addr,
   output logic                       qa_hit,
   output logic [DW-1:0]              qa_data,
   input  logic [4:0]                 qb_addr,
   output logic                       qb_hit,
   output logic [DW-1:0]              qb_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [4:0]    addr_mem_r [DEPTH];
   logic [DW-1:0] data_mem_r [DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;

   logic          push_s;
   logic          enq_s;
   logic          pop_s;
   logic [4:0]    push_addr_s;
   logic [DW-1:0] push_data_s;
   logic [DW:0]   qa_res_s;
   logic [DW:0]   qb_res_s;

   assign in_ready = (count_r < CW'(DEPTH));
   assign count    = count_r;

   // Youngest match wins: the retiring rf_* write is oldest, then queue entries head to tail.
   function automatic logic [DW:0] lookup(input logic [4:0] a);
      logic [DW:0]   r;
      logic [AW-1:0] idx;
      r = {(DW+1){1'b0}};
      if (rf_we && (rf_wreg == a)) begin
         r = {1'b1, rf_wdata};
      end else begin
         r = r;
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_r + AW'(i);
         if ((CW'(i) < count_r) && (addr_mem_r[idx] == a)) begin
            r = {1'b1, data_mem_r[idx]};
         end else begin
            r = r;
         end
      end
      if (a == 5'd0) begin
         r = {(DW+1){1'b0}};
      end else begin
         r = r;
      end
      return r;
   endfunction

   // Push/pop decode; writes to r0 complete the handshake but are never stored.
   always_comb begin
      push_s = in_valid & in_ready;
      if (in_link) begin
         push_addr_s = 5'd31;
         push_data_s = in_pc + DW'(8);
      end else begin
         push_addr_s = in_waddr;
         push_data_s = in_wdata;
      end
      enq_s = push_s & ~flush & (push_addr_s != 5'd0);
      pop_s = (count_r != {CW{1'b0}}) & ~flush;
   end

   // Forwarding lookups for both decode read ports.
   always_comb begin
      qa_res_s = lookup(qa_addr);
      qb_res_s = lookup(qb_addr);
      qa_hit   = qa_res_s[DW];
      qa_data  = qa_res_s[DW-1:0];
      qb_hit   = qb_res_s[DW];
      qb_data  = qb_res_s[DW-1:0];
   end

   // Queue storage; contents are qualified by count so no reset is needed.
   always_ff @(posedge clk) begin
      if (enq_s && !rst) begin
         addr_mem_r[wr_ptr_r] <= push_addr_s;
         data_mem_r[wr_ptr_r] <= push_data_s;
      end
   end

   // Pointers, occupancy and the registered register-file write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         rf_we    <= 1'b0;
         rf_wreg  <= 5'd0;
         rf_wdata <= {DW{1'b0}};
      end else if (flush) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         rf_we    <= 1'b0;
      end else begin
         if (enq_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
            rf_we    <= 1'b1;
            rf_wreg  <= addr_mem_r[rd_ptr_r];
            rf_wdata <= data_mem_r[rd_ptr_r];
         end else begin
            rf_we    <= 1'b0;
         end
         case ({enq_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed and random stimulus for regfile_wb_queue, checked against a queue-based model.
module tb_regfile_wb_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_link, flush;
   logic [4:0]  in_waddr, qa_addr, qb_addr, rf_wreg;
   logic [31:0] in_wdata, in_pc, rf_wdata, qa_data, qb_data;
   logic        rf_we, qa_hit, qb_hit;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   logic [36:0] mq[$];
   logic        m_we;
   logic [4:0]  m_wreg;
   logic [31:0] m_wdata;

   always #5 clk = ~clk;

   regfile_wb_queue #(.DEPTH(DEPTH), .DW(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_waddr(in_waddr), .in_wdata(in_wdata), .in_link(in_link), .in_pc(in_pc),
      .flush(flush), .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
      .qa_addr(qa_addr), .qa_hit(qa_hit), .qa_data(qa_data),
      .qb_addr(qb_addr), .qb_hit(qb_hit), .qb_data(qb_data), .count(count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] mlook(input logic [4:0] a);
      if (a == 5'd0) return 33'd0;
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i][36:32] == a) return {1'b1, mq[i][31:0]};
      if (m_we && m_wreg == a) return {1'b1, m_wdata};
      return 33'd0;
   endfunction

   task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic lk, input logic [31:0] pc, input logic fl,
                       input logic rs, input logic [4:0] ra, input logic [4:0] rb);
      logic [32:0] ea, eb;
      logic        full;
      logic [4:0]  pa;
      @(negedge clk);
      in_valid = v; in_waddr = a; in_wdata = d; in_link = lk; in_pc = pc;
      flush = fl; rst = rs; qa_addr = ra; qb_addr = rb;
      #1;
      ea = mlook(ra);
      eb = mlook(rb);
      chk("in_ready", in_ready, (mq.size() < DEPTH));
      chk("count_pre", count, mq.size());
      chk("qa_hit", qa_hit, ea[32]);
      chk("qa_data", qa_data, ea[31:0]);
      chk("qb_hit", qb_hit, eb[32]);
      chk("qb_data", qb_data, eb[31:0]);
      @(posedge clk);
      if (rs) begin
         mq.delete(); m_we = 1'b0; m_wreg = 5'd0; m_wdata = 32'd0;
      end else if (fl) begin
         mq.delete(); m_we = 1'b0;
      end else begin
         full = (mq.size() >= DEPTH);
         if (mq.size() > 0) begin
            {m_wreg, m_wdata} = mq.pop_front();
            m_we = 1'b1;
         end else begin
            m_we = 1'b0;
         end
         pa = lk ? 5'd31 : a;
         if (v && !full && pa != 5'd0) mq.push_back({pa, lk ? pc + 32'd8 : d});
      end
      #1;
      chk("rf_we", rf_we, m_we);
      chk("rf_wreg", rf_wreg, m_wreg);
      chk("rf_wdata", rf_wdata, m_wdata);
      chk("count_post", count, mq.size());
   endtask

   task automatic idle(input logic [4:0] ra);
      step(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, ra, 5'd0);
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [4:0] ra);
      step(1'b1, a, d, 1'b0, 32'd0, 1'b0, 1'b0, ra, 5'd31);
   endtask

   initial begin
      m_we = 1'b0; m_wreg = 5'd0; m_wdata = 32'd0;
      in_valid = 1'b0; in_waddr = 5'd0; in_wdata = 32'd0; in_link = 1'b0;
      in_pc = 32'd0; flush = 1'b0; rst = 1'b1; qa_addr = 5'd0; qb_addr = 5'd0;

      // Reset and idle
      step(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0);
      idle(5'd5);
      chk("reset_we", rf_we, 1'b0);
      chk("reset_count", count, 3'd0);
      chk("reset_ready", in_ready, 1'b1);
      chk("reset_hit", qa_hit, 1'b0);

      // Single write and forwarding before/during the write
      push(5'd5, 32'hDEADBEEF, 5'd5);
      idle(5'd5);
      chk("single_we", rf_we, 1'b1);
      chk("single_wreg", rf_wreg, 5'd5);
      chk("single_wdata", rf_wdata, 32'hDEADBEEF);
      idle(5'd5);

      // Link writes, including address wrap
      step(1'b1, 5'd3, 32'h1234, 1'b1, 32'hBFC00010, 1'b0, 1'b0, 5'd31, 5'd3);
      idle(5'd31);
      chk("link_wreg", rf_wreg, 5'd31);
      chk("link_wdata", rf_wdata, 32'hBFC00018);
      step(1'b1, 5'd3, 32'h1234, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 5'd31, 5'd3);
      idle(5'd31);
      chk("link_wrap", rf_wdata, 32'h00000004);

      // Consecutive pushes keep FIFO order
      for (int i = 0; i < 5; i++) push(5'(10 + i), 32'(100 + i), 5'(10 + i));
      idle(5'd14); idle(5'd14);

      // Same-register hazard and r0 write
      push(5'd7, 32'd1, 5'd7);
      push(5'd7, 32'd2, 5'd7);
      push(5'd7, 32'd3, 5'd7);
      push(5'd0, 32'h55, 5'd7);
      idle(5'd0);
      chk("r0_no_write", rf_wreg, 5'd7);
      idle(5'd7);

      // Flush and reset mid-operation
      push(5'd8, 32'd8, 5'd8);
      push(5'd9, 32'd9, 5'd9);
      step(1'b1, 5'd4, 32'd4, 1'b0, 32'd0, 1'b1, 1'b0, 5'd9, 5'd4);
      chk("flush_count", count, 3'd0);
      chk("flush_we", rf_we, 1'b0);
      idle(5'd4);
      push(5'd8, 32'd8, 5'd8);
      push(5'd9, 32'd9, 5'd9);
      step(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd9, 5'd8);
      chk("rst_we", rf_we, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 9) == 0), $urandom,
              ($urandom_range(0, 29) == 0), ($urandom_range(0, 99) == 0),
              5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
